// File: rtl/pacman_pkg.sv
// Shared types for the Pac-Man tile map datapath: tile codes, controller states,
// coordinate/address widths and the raw-code classifier.
package pacman_pkg;

    localparam int TILE_W  = 4;
    localparam int COORD_W = 5;
    localparam int ADDR_W  = 10;
    localparam int COUNT_W = 9;

    typedef enum logic [TILE_W-1:0] {
        TILE_EMPTY  = 4'd0,
        TILE_WALL   = 4'd1,
        TILE_FOOD   = 4'd2,
        TILE_PELLET = 4'd3
    } tile_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_WAIT,
        ST_WRITE,
        ST_REPORT
    } ctrl_state_t;

    // Codes 4..15 are unused map values and behave exactly like an empty tile.
    function automatic tile_t classify(input logic [TILE_W-1:0] code);
        case (code)
            4'd1:    return TILE_WALL;
            4'd2:    return TILE_FOOD;
            4'd3:    return TILE_PELLET;
            default: return TILE_EMPTY;
        endcase
    endfunction

endpackage

// File: rtl/lat_delay.sv
// Valid shift register that marks the cycle in which map RAM read data is valid,
// DEPTH cycles after the read strobe.
module lat_delay #(
    parameter int DEPTH = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic in_valid,
    output logic out_valid
);

    logic [DEPTH-1:0] shift;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shift <= '0;
        end else begin
            shift <= (shift << 1) | DEPTH'(in_valid);
        end
    end

    assign out_valid = shift[DEPTH-1];

endmodule

// File: rtl/tile_consume_ctrl.sv
// Resolves each Pac-Man move against the tile map RAM: read, classify, clear food, report.
// Build option: PELLET_CONSUME_EN makes power pellets cleared like food (but not counted).
module tile_consume_ctrl
    import pacman_pkg::*;
#(
    parameter int MAP_W   = 32,
    parameter int MAP_H   = 24,
    parameter int RAM_LAT = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               move_valid,
    output logic               move_ready,
    input  logic [COORD_W-1:0] pos_x,
    input  logic [COORD_W-1:0] pos_y,
    output logic [ADDR_W-1:0]  ram_addr,
    output logic               ram_rd_en,
    input  logic [TILE_W-1:0]  ram_rd_data,
    output logic               ram_wr_en,
    output logic [TILE_W-1:0]  ram_wr_data,
    output logic [TILE_W-1:0]  tile_out,
    output logic               tile_valid,
    output logic               move_block,
    output logic [COUNT_W-1:0] eaten_count
);

    ctrl_state_t state, state_next;
    tile_t       tile_q;
    tile_t       rd_tile;
    logic        in_range_q;
    logic        read_valid;
    logic        accept;
    logic        consume;

    assign accept      = move_valid && move_ready;
    assign rd_tile     = classify(ram_rd_data);
    assign ram_wr_data = TILE_EMPTY;

    lat_delay #(
        .DEPTH(RAM_LAT)
    ) u_lat_delay (
        .clk      (clk),
        .reset    (reset),
        .in_valid (ram_rd_en),
        .out_valid(read_valid)
    );

`ifdef PELLET_CONSUME_EN
    assign consume = (rd_tile == TILE_FOOD) || (rd_tile == TILE_PELLET);
`else
    assign consume = (rd_tile == TILE_FOOD);
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // The tile is classified in the last WAIT cycle, so food goes straight to WRITE.
    // NOTE: every output of this block gets a default first so no latch can be inferred.
    always_comb begin
        state_next = state;
        move_ready = 1'b0;
        ram_rd_en  = 1'b0;
        ram_wr_en  = 1'b0;
        tile_valid = 1'b0;
        tile_out   = '0;
        move_block = 1'b0;
        case (state)
            ST_IDLE: begin
                move_ready = 1'b1;
                if (move_valid) state_next = ST_READ;
            end
            ST_READ: begin
                ram_rd_en  = in_range_q;
                state_next = in_range_q ? ST_WAIT : ST_REPORT;
            end
            ST_WAIT: begin
                if (read_valid) state_next = consume ? ST_WRITE : ST_REPORT;
            end
            ST_WRITE: begin
                ram_wr_en  = 1'b1;
                state_next = ST_REPORT;
            end
            ST_REPORT: begin
                tile_valid = 1'b1;
                tile_out   = tile_q;
                move_block = (tile_q == TILE_WALL);
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ram_addr    <= '0;
            in_range_q  <= 1'b0;
            tile_q      <= TILE_EMPTY;
            eaten_count <= '0;
        end else begin
            if (accept) begin
                ram_addr   <= ADDR_W'(int'(pos_y) * MAP_W + int'(pos_x));
                in_range_q <= (int'(pos_x) < MAP_W) && (int'(pos_y) < MAP_H);
            end
            if (state == ST_READ && !in_range_q) begin
                tile_q <= TILE_WALL;
            end
            if (state == ST_WAIT && read_valid) begin
                tile_q <= rd_tile;
            end
            if (state == ST_REPORT && tile_q == TILE_FOOD && eaten_count != '1) begin
                eaten_count <= eaten_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_tile_consume_ctrl.sv
// Directed self-checking bench for tile_consume_ctrl with a 1-cycle-latency map RAM model.
module tb_tile_consume_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       move_valid;
    logic       move_ready;
    logic [4:0] pos_x;
    logic [4:0] pos_y;
    logic [9:0] ram_addr;
    logic       ram_rd_en;
    logic [3:0] ram_rd_data;
    logic       ram_wr_en;
    logic [3:0] ram_wr_data;
    logic [3:0] tile_out;
    logic       tile_valid;
    logic       move_block;
    logic [8:0] eaten_count;

    logic [3:0] mem [0:767];
    int         wr_total = 0;
    int         errors = 0;
    int         checks = 0;

    tile_consume_ctrl #(
        .MAP_W  (32),
        .MAP_H  (24),
        .RAM_LAT(1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .move_valid (move_valid),
        .move_ready (move_ready),
        .pos_x      (pos_x),
        .pos_y      (pos_y),
        .ram_addr   (ram_addr),
        .ram_rd_en  (ram_rd_en),
        .ram_rd_data(ram_rd_data),
        .ram_wr_en  (ram_wr_en),
        .ram_wr_data(ram_wr_data),
        .tile_out   (tile_out),
        .tile_valid (tile_valid),
        .move_block (move_block),
        .eaten_count(eaten_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_rd_en) ram_rd_data <= mem[ram_addr];
        if (ram_wr_en) begin
            mem[ram_addr] <= ram_wr_data;
            wr_total++;
        end
    end

    // Issues one move and records, per cycle after accept (+1..+10), what the DUT did.
    task automatic run_move(input logic [4:0] x, input logic [4:0] y,
                            output int rd_c, output int wr_c, output int val_c,
                            output int pulses, output int wr_cnt,
                            output logic [3:0] tile, output logic blk,
                            output logic [9:0] wa, output logic [3:0] wd,
                            output logic ok);
        rd_c = -1; wr_c = -1; val_c = -1; pulses = 0; wr_cnt = 0;
        tile = 4'hf; blk = 1'b0; wa = '1; wd = 4'hf; ok = 1'b0;
        @(negedge clk);
        move_valid = 1'b1;
        pos_x = x;
        pos_y = y;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (move_ready) ok = 1'b1;
            else @(negedge clk);
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL accept_timeout: move_ready=%0b, required 1 within 20 cycles", move_ready);
            move_valid = 1'b0;
            return;
        end
        @(negedge clk);
        move_valid = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            if (ram_rd_en) rd_c = k;
            if (ram_wr_en) begin
                wr_c = k;
                wr_cnt++;
                wa = ram_addr;
                wd = ram_wr_data;
            end
            if (tile_valid) begin
                if (val_c < 0) val_c = k;
                pulses++;
                tile = tile_out;
                blk  = move_block;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        checks++;
        if (move_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %0b, required 1", move_ready); end
        checks++;
        if ({tile_valid, tile_out, move_block} !== 6'd0) begin
            errors++; $display("FAIL reset_tile: valid=%0b tile=%0d block=%0b, required all 0", tile_valid, tile_out, move_block);
        end
        checks++;
        if ({ram_rd_en, ram_wr_en, ram_addr, eaten_count} !== 21'd0) begin
            errors++; $display("FAIL reset_ram: rd=%0b wr=%0b addr=%0d eaten=%0d, required all 0", ram_rd_en, ram_wr_en, ram_addr, eaten_count);
        end
    endtask

    task automatic test_food;
        int rd_c, wr_c, val_c, pulses, wr_cnt;
        logic [3:0] tile, wd;
        logic blk, ok;
        logic [9:0] wa;
        mem[67] = 4'd2;
        run_move(5'd3, 5'd2, rd_c, wr_c, val_c, pulses, wr_cnt, tile, blk, wa, wd, ok);
        checks++;
        if (rd_c !== 1 || wr_c !== 3 || val_c !== 4) begin
            errors++; $display("FAIL food_timing: rd=+%0d wr=+%0d valid=+%0d, required +1 +3 +4", rd_c, wr_c, val_c);
        end
        checks++;
        if (wa !== 10'd67 || wd !== 4'd0) begin
            errors++; $display("FAIL food_write: addr=%0d data=%0d, required 67 0", wa, wd);
        end
        checks++;
        if (tile !== 4'd2 || pulses !== 1 || blk !== 1'b0) begin
            errors++; $display("FAIL food_report: tile=%0d pulses=%0d block=%0b, required 2 1 0", tile, pulses, blk);
        end
        checks++;
        if (eaten_count !== 9'd1 || mem[67] !== 4'd0) begin
            errors++; $display("FAIL food_effect: eaten=%0d ram=%0d, required 1 0", eaten_count, mem[67]);
        end
    endtask

    task automatic test_same_tile;
        int rd_c, wr_c, val_c, pulses, wr_cnt;
        logic [3:0] tile, wd;
        logic blk, ok;
        logic [9:0] wa;
        run_move(5'd3, 5'd2, rd_c, wr_c, val_c, pulses, wr_cnt, tile, blk, wa, wd, ok);
        checks++;
        if (tile !== 4'd0 || val_c !== 3 || wr_cnt !== 0) begin
            errors++; $display("FAIL same_tile: tile=%0d valid=+%0d writes=%0d, required 0 +3 0", tile, val_c, wr_cnt);
        end
        checks++;
        if (eaten_count !== 9'd1) begin errors++; $display("FAIL same_tile_count: got %0d, required 1", eaten_count); end
    endtask

    task automatic test_wall;
        int rd_c, wr_c, val_c, pulses, wr_cnt;
        logic [3:0] tile, wd;
        logic blk, ok;
        logic [9:0] wa;
        mem[170] = 4'd1;
        run_move(5'd10, 5'd5, rd_c, wr_c, val_c, pulses, wr_cnt, tile, blk, wa, wd, ok);
        checks++;
        if (tile !== 4'd1 || blk !== 1'b1 || pulses !== 1 || wr_cnt !== 0 || rd_c !== 1) begin
            errors++; $display("FAIL wall: tile=%0d block=%0b pulses=%0d writes=%0d rd=+%0d, required 1 1 1 0 +1", tile, blk, pulses, wr_cnt, rd_c);
        end
    endtask

    task automatic test_out_of_range;
        int rd_c, wr_c, val_c, pulses, wr_cnt;
        logic [3:0] tile, wd;
        logic blk, ok;
        logic [9:0] wa;
        run_move(5'd0, 5'd24, rd_c, wr_c, val_c, pulses, wr_cnt, tile, blk, wa, wd, ok);
        checks++;
        if (rd_c !== -1 || wr_cnt !== 0 || val_c !== 2 || tile !== 4'd1 || blk !== 1'b1) begin
            errors++; $display("FAIL oob_y24: rd=+%0d writes=%0d valid=+%0d tile=%0d block=%0b, required none 0 +2 1 1", rd_c, wr_cnt, val_c, tile, blk);
        end
        run_move(5'd31, 5'd31, rd_c, wr_c, val_c, pulses, wr_cnt, tile, blk, wa, wd, ok);
        checks++;
        if (rd_c !== -1 || val_c !== 2 || tile !== 4'd1 || pulses !== 1) begin
            errors++; $display("FAIL oob_y31: rd=+%0d valid=+%0d tile=%0d pulses=%0d, required none +2 1 1", rd_c, val_c, tile, pulses);
        end
    endtask

    task automatic test_pellet;
        int rd_c, wr_c, val_c, pulses, wr_cnt;
        logic [3:0] tile, wd;
        logic blk, ok;
        logic [9:0] wa;
        mem[132] = 4'd3;
        run_move(5'd4, 5'd4, rd_c, wr_c, val_c, pulses, wr_cnt, tile, blk, wa, wd, ok);
        checks++;
        if (tile !== 4'd3 || eaten_count !== 9'd1) begin
            errors++; $display("FAIL pellet_report: tile=%0d eaten=%0d, required 3 1", tile, eaten_count);
        end
`ifdef PELLET_CONSUME_EN
        checks++;
        if (wr_cnt !== 1 || wr_c !== 3 || val_c !== 4 || mem[132] !== 4'd0) begin
            errors++; $display("FAIL pellet_consume: writes=%0d wr=+%0d valid=+%0d ram=%0d, required 1 +3 +4 0", wr_cnt, wr_c, val_c, mem[132]);
        end
`else
        checks++;
        if (wr_cnt !== 0 || val_c !== 3 || mem[132] !== 4'd3) begin
            errors++; $display("FAIL pellet_keep: writes=%0d valid=+%0d ram=%0d, required 0 +3 3", wr_cnt, val_c, mem[132]);
        end
`endif
    endtask

    task automatic test_unknown_code;
        int rd_c, wr_c, val_c, pulses, wr_cnt;
        logic [3:0] tile, wd;
        logic blk, ok;
        logic [9:0] wa;
        mem[0] = 4'd9;
        run_move(5'd0, 5'd0, rd_c, wr_c, val_c, pulses, wr_cnt, tile, blk, wa, wd, ok);
        checks++;
        if (tile !== 4'd0 || blk !== 1'b0 || wr_cnt !== 0 || mem[0] !== 4'd9) begin
            errors++; $display("FAIL unknown_code: tile=%0d block=%0b writes=%0d ram=%0d, required 0 0 0 9", tile, blk, wr_cnt, mem[0]);
        end
    endtask

    task automatic test_back_to_back;
        int idx = 0;
        int pulses = 0;
        int ready_cnt = 0;
        int bad_idle = 0;
        int start_wr = wr_total;
        logic pend = 1'b0;
        logic [8:0] start_eaten = eaten_count;
        for (int i = 0; i < 5; i++) mem[321 + i] = 4'd2;
        @(negedge clk);
        move_valid = 1'b1;
        pos_x = 5'd1;
        pos_y = 5'd10;
        for (int c = 0; c < 40; c++) begin
            if (pend) begin
                idx++;
                if (idx < 5) pos_x = 5'(idx + 1);
                else move_valid = 1'b0;
                pend = 1'b0;
            end
            if (tile_valid && tile_out == 4'd2) pulses++;
            if (!tile_valid && tile_out != 4'd0) bad_idle++;
            if (move_valid && move_ready) begin
                pend = 1'b1;
                ready_cnt++;
            end
            @(negedge clk);
        end
        checks++;
        if (pulses !== 5 || ready_cnt !== 5 || bad_idle !== 0) begin
            errors++; $display("FAIL b2b_pulses: pulses=%0d ready_cycles=%0d stray=%0d, required 5 5 0", pulses, ready_cnt, bad_idle);
        end
        checks++;
        if (eaten_count !== start_eaten + 9'd5 || wr_total - start_wr !== 5) begin
            errors++; $display("FAIL b2b_count: eaten=%0d writes=%0d, required %0d 5", eaten_count, wr_total - start_wr, start_eaten + 9'd5);
        end
        checks++;
        if ({mem[321], mem[322], mem[323], mem[324], mem[325]} !== 20'd0) begin
            errors++; $display("FAIL b2b_ram: tiles=%h, required 00000", {mem[321], mem[322], mem[323], mem[324], mem[325]});
        end
    endtask

    task automatic test_reset_mid;
        int rd_c, wr_c, val_c, pulses, wr_cnt;
        int start_wr;
        logic [3:0] tile, wd;
        logic blk, ok;
        logic [9:0] wa;
        mem[231] = 4'd2;
        start_wr = wr_total;
        @(negedge clk);
        move_valid = 1'b1;
        pos_x = 5'd7;
        pos_y = 5'd7;
        checks++;
        if (move_ready !== 1'b1) begin errors++; $display("FAIL midreset_ready: got %0b, required 1", move_ready); end
        @(negedge clk);
        move_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        checks++;
        if ({ram_rd_en, ram_wr_en, tile_valid, tile_out, move_block, ram_addr, eaten_count} !== 27'd0 || move_ready !== 1'b1) begin
            errors++; $display("FAIL midreset_outputs: rd=%0b wr=%0b valid=%0b tile=%0d addr=%0d eaten=%0d ready=%0b, required zeros and ready 1",
                               ram_rd_en, ram_wr_en, tile_valid, tile_out, ram_addr, eaten_count, move_ready);
        end
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (wr_total !== start_wr || mem[231] !== 4'd2) begin
            errors++; $display("FAIL midreset_nowrite: writes=%0d ram=%0d, required 0 2", wr_total - start_wr, mem[231]);
        end
        run_move(5'd7, 5'd7, rd_c, wr_c, val_c, pulses, wr_cnt, tile, blk, wa, wd, ok);
        checks++;
        if (tile !== 4'd2 || eaten_count !== 9'd1 || mem[231] !== 4'd0) begin
            errors++; $display("FAIL midreset_retry: tile=%0d eaten=%0d ram=%0d, required 2 1 0", tile, eaten_count, mem[231]);
        end
    endtask

    initial begin
        reset       = 1'b1;
        move_valid  = 1'b0;
        pos_x       = '0;
        pos_y       = '0;
        ram_rd_data = '0;
        for (int i = 0; i < 768; i++) mem[i] = 4'd0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        test_reset();
        test_food();
        test_same_tile();
        test_wall();
        test_out_of_range();
        test_pellet();
        test_unknown_code();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
